// File: rtl/booth_mult_pkg.sv
// Shared types and sizing helper for the radix-4 Booth sequential multiplier.
package booth_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    PLUS1  = 3'd1,
    PLUS2  = 3'd2,
    MINUS1 = 3'd3,
    MINUS2 = 3'd4
  } booth_op_t;

  // Radix-4 iterations needed for a width-bit operand extended by two bits.
  function automatic int unsigned steps(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoding of a 3-bit multiplier window {b[i+1], b[i], b[i-1]}.
module booth_recoder
  import booth_mult_pkg::*;
(
  input  logic [2:0] window,
  output booth_op_t  op_c
);

  always_comb begin
    op_c = ZERO;
    case (window)
      3'b001, 3'b010: op_c = PLUS1;
      3'b011:         op_c = PLUS2;
      3'b100:         op_c = MINUS2;
      3'b101, 3'b110: op_c = MINUS1;
      default:        op_c = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation,
// with valid/ready handshakes on both sides and zero-bubble back-to-back issue.
module booth_seq_multiplier
  import booth_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned STEPS = steps(WIDTH);
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam int unsigned EW    = WIDTH + 2;   // extended operand width
  localparam int unsigned HW    = EW + 2;      // upper accumulator, headroom for +-2A
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned LO_W  = PW - EW;     // product bits taken from the upper half

  state_t            state;
  state_t            state_nxt;
  logic              accept_c;
  logic              step_c;
  logic              last_c;

  logic [EW-1:0]     mcand;
  logic [EW-1:0]     mplier;
  logic              prev;
  logic [HW-1:0]     acc_hi;
  logic [CNT_W-1:0]  step_cnt;

  logic [EW-1:0]     a_ext_c;
  logic [EW-1:0]     b_ext_c;
  booth_op_t         op_c;
  logic [HW-1:0]     a_x_c;
  logic [HW-1:0]     a2_c;
  logic [HW-1:0]     addend_c;
  logic [HW-1:0]     sum_c;
  logic [HW-1:0]     acc_hi_nxt_c;
  logic [EW-1:0]     mplier_nxt_c;
  logic [PW-1:0]     product_nxt_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: if (last_c)   state_nxt = DONE;
      DONE: if (out_ready) state_nxt = in_valid ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs; in_ready looks through to out_ready so DONE can hand over directly
  always_comb begin
    in_ready = 1'b0;
    step_c   = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      CALC:    step_c   = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept_c = in_valid && in_ready;
    last_c   = step_c && (step_cnt == CNT_W'(STEPS - 1));
  end

  always_comb begin
    a_ext_c = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
    b_ext_c = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}     : {2'b00, multiplier};
  end

  booth_recoder u_recoder (
    .window ({mplier[1:0], prev}),
    .op_c   (op_c)
  );

  // One Booth step: add the recoded partial product, then shift {acc_hi, mplier, prev} right by two
  always_comb begin
    a_x_c = {{2{mcand[EW-1]}}, mcand};
    a2_c  = {mcand[EW-1], mcand, 1'b0};
    addend_c = '0;
    case (op_c)
      PLUS1:   addend_c = a_x_c;
      PLUS2:   addend_c = a2_c;
      MINUS1:  addend_c = HW'(-a_x_c);
      MINUS2:  addend_c = HW'(-a2_c);
      default: addend_c = '0;
    endcase
    sum_c         = acc_hi + addend_c;
    acc_hi_nxt_c  = {{2{sum_c[HW-1]}}, sum_c[HW-1:2]};
    mplier_nxt_c  = {sum_c[1:0], mplier[EW-1:2]};
    product_nxt_c = {acc_hi_nxt_c[LO_W-1:0], mplier_nxt_c};
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      prev      <= 1'b0;
      acc_hi    <= '0;
      step_cnt  <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (accept_c) begin
        mcand    <= a_ext_c;
        mplier   <= b_ext_c;
        prev     <= 1'b0;
        acc_hi   <= '0;
        step_cnt <= '0;
      end else if (step_c) begin
        acc_hi   <= acc_hi_nxt_c;
        mplier   <= mplier_nxt_c;
        prev     <= mplier[1];
        step_cnt <= step_cnt + CNT_W'(1);
        if (last_c) product <= product_nxt_c;
      end
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == CALC);
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench: driver pushes reference products, monitor pops and compares on out_valid.
module tb_booth_seq_multiplier;

  localparam int unsigned W     = 8;
  localparam int unsigned STEPS = W / 2 + 1;
  localparam int          N_RND = 6000;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [W-1:0]     multiplicand;
  logic [W-1:0]     multiplier;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   product;
  logic             busy;

  int               checks;
  int               errors;
  int               cyc;
  int               ready_mode;   // 0 random, 1 always ready, 2 stalled
  logic [2*W-1:0]   exp_q[$];
  int               acc_q[$];
  logic             was_valid;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product, truncated to 2W bits
  function automatic logic [2*W-1:0] ref_prod(input logic s, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(x * y);
  endfunction

  // Offer one operand pair from a negedge; returns at the negedge after acceptance
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int waited);
    int n;
    n = 0;
    in_valid = 1'b1;
    is_signed = s;
    multiplicand = a;
    multiplier = b;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    waited = n;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=stalled expected=accept");
    end else begin
      exp_q.push_back(ref_prod(s, a, b));
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_queue_empty", longint'(exp_q.size()), 0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    #1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("wait_out_valid", longint'(out_valid), 1);
  endtask

  // Consumer / monitor
  initial begin
    out_ready = 1'b0;
    was_valid = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 9) < 8);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h expected=none", product);
        end else begin
          if (!was_valid) check_eq("latency", longint'(cyc - acc_q[0]), longint'(STEPS));
          check_eq("product", longint'(product), longint'(exp_q[0]));
          if (!out_ready) check_eq("in_ready_while_stalled", longint'(in_ready), 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      was_valid = out_valid;
    end
  end

  initial begin
    int w;
    logic s;
    logic [W-1:0] a, b;
    checks = 0;
    errors = 0;
    ready_mode = 1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    is_signed = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_in_ready", longint'(in_ready), 1);
    check_eq("reset_out_valid", longint'(out_valid), 0);
    check_eq("reset_busy", longint'(busy), 0);
    check_eq("reset_product", longint'(product), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed extreme, then busy during CALC
    issue(1'b1, 8'h80, 8'h80, w);
    #1;
    check_eq("busy_in_calc", longint'(busy), 1);
    check_eq("out_valid_in_calc", longint'(out_valid), 0);
    @(negedge clk);
    drain();

    // Back-to-back directed corners
    issue(1'b0, 8'hFF, 8'hFF, w);
    issue(1'b1, 8'hFF, 8'hFF, w);
    issue(1'b1, 8'hFF, 8'h7F, w);
    issue(1'b0, 8'hFF, 8'h7F, w);
    drain();

    // Stall the consumer for ten cycles, then release with a new operand pair waiting
    ready_mode = 2;
    issue(1'b0, 8'd200, 8'd3, w);
    wait_valid();
    repeat (10) @(negedge clk);
    #2 ready_mode = 1;
    @(negedge clk);
    issue(1'b1, 8'h9C, 8'h05, w);
    check_eq("zero_bubble_accept_wait", longint'(w), 0);
    drain();

    // Reset during the third CALC cycle
    issue(1'b1, 8'd100, 8'd3, w);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check_eq("midcalc_rst_out_valid", longint'(out_valid), 0);
    check_eq("midcalc_rst_in_ready", longint'(in_ready), 1);
    check_eq("midcalc_rst_busy", longint'(busy), 0);
    check_eq("midcalc_rst_product", longint'(product), 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 8'd7, 8'hFA, w);
    drain();

    // Randomized traffic with producer gaps and consumer stalls
    ready_mode = 0;
    for (int i = 0; i < N_RND; i++) begin
      if ($urandom_range(0, 9) == 0) @(negedge clk);
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       a = 8'h80;
        1:       a = 8'hFF;
        2:       a = 8'h7F;
        3:       a = 8'h00;
        default: a = 8'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = 8'h80;
        1:       b = 8'hFF;
        2:       b = 8'h01;
        default: b = 8'($urandom);
      endcase
      issue(s, a, b, w);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
